// File: rtl/jstk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jstk_pkg
//  Description : Shared constants, FSM state type and transmit-byte mapping
//                for the joystick SPI responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package jstk_pkg;

  localparam int JSTK_FRAME_BYTES = 5;
  localparam int JSTK_LED_CMD_BIT = 7;

  // Position of each field within the response frame
  localparam logic [2:0] BYTE_X_LO = 3'd0;
  localparam logic [2:0] BYTE_X_HI = 3'd1;
  localparam logic [2:0] BYTE_Y_LO = 3'd2;
  localparam logic [2:0] BYTE_Y_HI = 3'd3;
  localparam logic [2:0] BYTE_BTN  = 3'd4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } jstk_state_e;

  // Response byte for a given frame index; indices past the button byte read 0.
  function automatic logic [7:0] jstk_tx_byte(input logic [2:0] idx,
                                              input logic [9:0] x,
                                              input logic [9:0] y,
                                              input logic [2:0] btn);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      BYTE_X_LO: b = x[7:0];
      BYTE_X_HI: b = {6'b0, x[9:8]};
      BYTE_Y_LO: b = y[7:0];
      BYTE_Y_HI: b = {6'b0, y[9:8]};
      BYTE_BTN:  b = {5'b0, btn};
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jstk_spi_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : jstk_spi_responder_if
//  Description : SPI link between joystick master and responder.
//                cs   - chip select, active low
//                sclk - serial clock, idle low (mode 0)
//                mosi - master-out data
//                miso - slave-out data, MSB first
//  Revision    : 1.0 - initial release
// ============================================================================
interface jstk_spi_responder_if;
  logic cs;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output cs, output sclk, output mosi, input miso);
  modport slave  (input cs, input sclk, input mosi, output miso);
endinterface
`default_nettype wire

// File: rtl/jstk_spi_responder_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : STAGES-deep synchronizer for an asynchronous input with
//                single-cycle rise/fall pulses on the synchronized level.
//  Ports       : clk, rst    - system clock, synchronous active-high reset
//                din         - asynchronous input
//                level       - synchronized level
//                rise / fall - one-cycle edge pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule
`default_nettype wire

// File: rtl/jstk_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : jstk_spi_responder
//  Description : SPI mode-0 slave emulating the joystick peripheral. Returns
//                X, Y and button state in a NUM_BYTES frame and captures the
//                LED command carried in byte 0.
//  Ports       : clk, rst     - system clock, synchronous active-high reset
//                spi          - SPI link (slave modport)
//                x_pos, y_pos - 10-bit positions reported in the frame
//                buttons      - {btn2, btn1, trigger}
//                led_cmd      - last valid LED command
//                frame_done   - pulse: frame closed with exactly NUM_BYTES
//                frame_err    - pulse: frame closed short/long/partial
//                busy         - high while a frame is active
//  Revision    : 1.0 - initial release
// ============================================================================
module jstk_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_BYTES   = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  jstk_spi_responder_if.slave        spi,
  input  logic [9:0]                 x_pos,
  input  logic [9:0]                 y_pos,
  input  logic [2:0]                 buttons,
  output logic [1:0]                 led_cmd,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic                       busy
);
  import jstk_pkg::*;

  localparam logic [3:0] NUM_BYTES_W = 4'(NUM_BYTES);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst(rst), .din(spi.cs),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(spi.sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk(clk), .rst(rst), .din(spi.mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  jstk_state_e state_q, state_d;
  logic [9:0]  x_snap_q, x_snap_d;
  logic [9:0]  y_snap_q, y_snap_d;
  logic [2:0]  btn_snap_q, btn_snap_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [1:0]  led_q, led_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  rx_next;

  always_comb begin
    state_d    = state_q;
    x_snap_d   = x_snap_q;
    y_snap_d   = y_snap_q;
    btn_snap_d = btn_snap_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    led_d      = led_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rx_next    = {rx_q[6:0], mosi_lvl};

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = ACTIVE;
          x_snap_d   = x_pos;
          y_snap_d   = y_pos;
          btn_snap_d = buttons;
          // Byte 0 comes from the live inputs: they are the snapshot too.
          tx_d       = jstk_tx_byte(BYTE_X_LO, x_pos, y_pos, buttons);
          rx_d       = 8'h00;
          bit_cnt_d  = 3'd0;
          byte_idx_d = 3'd0;
        end
      end

      ACTIVE: begin
        // CS rise has priority over any SCLK edge seen in the same cycle.
        if (cs_rise) begin
          state_d = IDLE;
          tx_d    = 8'h00;
          if ({1'b0, byte_idx_q} == NUM_BYTES_W && bit_cnt_q == 3'd0) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          rx_d      = rx_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_idx_q != 3'd7) begin
              byte_idx_d = byte_idx_q + 3'd1;
            end
            if (byte_idx_q == 3'd0 && rx_next[JSTK_LED_CMD_BIT]) begin
              led_d = rx_next[1:0];
            end
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q != 3'd0) begin
            tx_d = {tx_q[6:0], 1'b0};
          end else if ({1'b0, byte_idx_q} < NUM_BYTES_W) begin
            tx_d = jstk_tx_byte(byte_idx_q, x_snap_q, y_snap_q, btn_snap_q);
          end else begin
            tx_d = 8'h00;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_snap_q   <= '0;
      y_snap_q   <= '0;
      btn_snap_q <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      led_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_snap_q   <= x_snap_d;
      y_snap_q   <= y_snap_d;
      btn_snap_q <= btn_snap_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      led_q      <= led_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign spi.miso   = tx_q[7];
  assign led_cmd    = led_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = (state_q == ACTIVE);

  // Synchronizer outputs this block has no use for.
  logic unused_sig;
  assign unused_sig = ^{cs_lvl, sclk_lvl, mosi_rise, mosi_fall, rx_q[7]};

endmodule
`default_nettype wire

// File: tb/tb_jstk_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jstk_spi_responder
//  Description : Directed bench for jstk_spi_responder. A vector table drives
//                whole frames; hand-written sequences cover mid-frame input
//                changes and reset during a frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jstk_spi_responder;

  localparam int HALF = 8;  // SCLK half period in CLK cycles (SCLK = CLK/16)

  logic       clk;
  logic       rst;
  logic [9:0] x_pos, y_pos;
  logic [2:0] buttons;
  logic [1:0] led_cmd;
  logic       frame_done, frame_err, busy;

  jstk_spi_responder_if spi_if ();

  jstk_spi_responder #(.SYNC_STAGES(2), .NUM_BYTES(5)) dut (
    .clk(clk), .rst(rst), .spi(spi_if),
    .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons),
    .led_cmd(led_cmd), .frame_done(frame_done), .frame_err(frame_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge
  int done_cnt = 0;
  int err_cnt  = 0;
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift nbits of tx out MSB first; MISO sampled just before each rise.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_if.mosi = tx[7-i];
      cycles(HALF);
      rx = {rx[6:0], spi_if.miso};
      spi_if.sclk = 1'b1;
      cycles(HALF);
      spi_if.sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_if.cs = 1'b0;
    cycles(HALF);
  endtask

  task automatic cs_high();
    cycles(HALF);
    spi_if.cs = 1'b1;
    cycles(HALF);
  endtask

  typedef struct {
    logic [9:0]      x;
    logic [9:0]      y;
    logic [2:0]      btn;
    logic [7:0]      b0;
    int              nbytes;
    int              xbits;
    logic [6:0][7:0] exp_rx;
    logic [1:0]      exp_led;
    logic            exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0]      b;
    logic [6:0][7:0] rx;
    int              d0, e0;

    vecs[0] = '{10'h2A5, 10'h13C, 3'b101, 8'h81, 5, 0,
                {8'h00, 8'h00, 8'h05, 8'h01, 8'h3C, 8'h02, 8'hA5}, 2'b01, 1'b1};
    vecs[1] = '{10'h2A5, 10'h13C, 3'b101, 8'h03, 5, 0,
                {8'h00, 8'h00, 8'h05, 8'h01, 8'h3C, 8'h02, 8'hA5}, 2'b01, 1'b1};
    vecs[2] = '{10'h2A5, 10'h13C, 3'b101, 8'h82, 3, 0,
                {8'h00, 8'h00, 8'h05, 8'h01, 8'h3C, 8'h02, 8'hA5}, 2'b10, 1'b0};
    vecs[3] = '{10'h2A5, 10'h13C, 3'b101, 8'h00, 5, 4,
                {8'h00, 8'h00, 8'h05, 8'h01, 8'h3C, 8'h02, 8'hA5}, 2'b10, 1'b0};
    vecs[4] = '{10'h3FF, 10'h000, 3'b111, 8'h83, 7, 0,
                {8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h03, 8'hFF}, 2'b11, 1'b0};
    vecs[5] = '{10'h155, 10'h2AA, 3'b010, 8'h80, 5, 0,
                {8'h00, 8'h00, 8'h02, 8'h02, 8'hAA, 8'h01, 8'h55}, 2'b00, 1'b1};

    rst = 1'b1;
    spi_if.cs = 1'b1; spi_if.sclk = 1'b0; spi_if.mosi = 1'b0;
    x_pos = '0; y_pos = '0; buttons = '0;
    cycles(4);
    chk("reset_miso", 32'(spi_if.miso), 32'd0);
    chk("reset_led",  32'(led_cmd),     32'd0);
    chk("reset_busy", 32'(busy),        32'd0);
    chk("reset_done", 32'(frame_done),  32'd0);
    chk("reset_err",  32'(frame_err),   32'd0);
    rst = 1'b0;
    cycles(HALF);

    // ---------------- table-driven frames ----------------
    for (int v = 0; v < 6; v++) begin
      x_pos = vecs[v].x; y_pos = vecs[v].y; buttons = vecs[v].btn;
      d0 = done_cnt; e0 = err_cnt;
      cs_low();
      chk($sformatf("v%0d_busy_active", v), 32'(busy), 32'd1);
      for (int i = 0; i < vecs[v].nbytes; i++) begin
        xfer((i == 0) ? vecs[v].b0 : 8'h00, 8, b);
        chk($sformatf("v%0d_miso_byte%0d", v, i), 32'(b), 32'(vecs[v].exp_rx[i]));
      end
      if (vecs[v].xbits > 0) xfer(8'h00, vecs[v].xbits, b);
      cs_high();
      chk($sformatf("v%0d_busy_idle", v), 32'(busy), 32'd0);
      chk($sformatf("v%0d_led", v), 32'(led_cmd), 32'(vecs[v].exp_led));
      chk($sformatf("v%0d_done_pulses", v), 32'(done_cnt - d0), 32'(vecs[v].exp_done ? 1 : 0));
      chk($sformatf("v%0d_err_pulses", v), 32'(err_cnt - e0), 32'(vecs[v].exp_done ? 0 : 1));
    end

    // ---------------- X changed mid-frame ----------------
    x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
    cs_low();
    for (int i = 0; i < 5; i++) begin
      xfer(8'h00, 8, rx[i]);
      if (i == 0) x_pos = 10'h000;
    end
    cs_high();
    chk("midx_byte0", 32'(rx[0]), 32'h0A5);
    chk("midx_byte1", 32'(rx[1]), 32'h002);
    chk("midx_byte4", 32'(rx[4]), 32'h005);
    d0 = done_cnt;
    cs_low();
    for (int i = 0; i < 5; i++) xfer(8'h00, 8, rx[i]);
    cs_high();
    chk("nextx_byte0", 32'(rx[0]), 32'h000);
    chk("nextx_byte1", 32'(rx[1]), 32'h000);
    chk("nextx_byte2", 32'(rx[2]), 32'h03C);
    chk("nextx_done",  32'(done_cnt - d0), 32'd1);

    // ---------------- reset during byte 2 ----------------
    x_pos = 10'h2A5;
    d0 = done_cnt; e0 = err_cnt;
    cs_low();
    xfer(8'h81, 8, b);
    xfer(8'h00, 8, b);
    xfer(8'h00, 3, b);
    chk("rstmid_led_before",  32'(led_cmd), 32'd1);
    chk("rstmid_busy_before", 32'(busy),    32'd1);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(1);
    chk("rstmid_miso", 32'(spi_if.miso), 32'd0);
    chk("rstmid_led",  32'(led_cmd),     32'd0);
    chk("rstmid_busy", 32'(busy),        32'd0);
    // remaining clocking with CS still low must be ignored
    xfer(8'hFF, 5, b);
    xfer(8'hFF, 8, b);
    xfer(8'hFF, 8, b);
    chk("rstmid_busy_ignored", 32'(busy), 32'd0);
    chk("rstmid_miso_ignored", 32'(b),    32'd0);
    cs_high();
    chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rstmid_no_err",  32'(err_cnt - e0),  32'd0);
    chk("rstmid_led_kept", 32'(led_cmd), 32'd0);
    d0 = done_cnt; e0 = err_cnt;
    cs_low();
    for (int i = 0; i < 5; i++) xfer((i == 0) ? 8'h82 : 8'h00, 8, rx[i]);
    cs_high();
    chk("post_rst_byte0", 32'(rx[0]), 32'h0A5);
    chk("post_rst_byte4", 32'(rx[4]), 32'h005);
    chk("post_rst_led",   32'(led_cmd), 32'd2);
    chk("post_rst_done",  32'(done_cnt - d0), 32'd1);
    chk("post_rst_err",   32'(err_cnt - e0),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jstk_spi_responder.md
# jstk_spi_responder

SPI mode-0 slave that emulates the joystick peripheral on the CS2/SCLK2/MOSI/MISO link. It answers the 5-byte joystick transaction with X position, Y position and button state, and it captures the LED command byte sent by the master. It lets the direction-readout logic be exercised on-chip or board-to-board without the physical joystick, and it serves as the reference responder in the top-level bench.

## Interface
- SYNC_STAGES, 2, flip-flop stages on CS/SCLK/MOSI before edge detection (≥2)
- NUM_BYTES, 5, bytes in a complete frame

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset; synchronous, active-high
- CS  in  1  chip select from master, active-low, asynchronous to CLK
- SCLK  in  1  serial clock from master, idle low, asynchronous
- MOSI  in  1  master-out data, asynchronous
- MISO  out  1  slave-out data, MSB first
- X_POS  in  10  X value reported in the frame
- Y_POS  in  10  Y value reported in the frame
- BUTTONS  in  3  button bits {btn2,btn1,trigger}
- LED_CMD  out  2  last valid LED command, bits [1:0] of byte 0
- FRAME_DONE  out  1  one-cycle pulse when a frame closes with exactly NUM_BYTES bytes
- FRAME_ERR  out  1  one-cycle pulse when a frame closes short, or with a partial byte
- BUSY  out  1  high while a frame is active

## Operation
- CS, SCLK and MOSI each pass through SYNC_STAGES FFs. Edges are detected on the synchronized value.
- FSM states: IDLE and ACTIVE.
- IDLE → ACTIVE on a synced CS fall:
  - snapshot X_POS, Y_POS and BUTTONS
  - load tx_shift with byte 0
  - drive MISO from tx bit 7
  - clear bit_cnt (3b) and byte_idx (3b)
  - assert BUSY
- Tx bytes: 0 = X[7:0], 1 = {6'b0,X[9:8]}, 2 = Y[7:0], 3 = {6'b0,Y[9:8]}, 4 = {5'b0,BUTTONS}. Any byte_idx ≥ NUM_BYTES sends 0x00.
- ACTIVE, synced SCLK rise:
  - rx_shift <= {rx_shift[6:0], MOSI_sync}
  - bit_cnt increments
  - when bit_cnt wraps 7→0, the byte is complete and byte_idx increments, saturating at 7
  - if the completed byte is byte 0 and rx bit 7 = 1, LED_CMD <= rx[1:0]; otherwise LED_CMD holds
- ACTIVE, synced SCLK fall:
  - if bit_cnt ≠ 0, shift tx_shift left and present the next bit
  - if bit_cnt = 0 (byte boundary), load the byte for byte_idx and present its bit 7
- ACTIVE → IDLE on a synced CS rise:
  - FRAME_DONE pulses if byte_idx = NUM_BYTES and bit_cnt = 0
  - FRAME_ERR pulses otherwise; this covers overlong, short and partial frames
  - BUSY deasserts and MISO returns to 0
- Simultaneous SCLK edge and CS rise in the same cycle: the CS rise wins and the SCLK edge is ignored.
- SCLK edges while in IDLE are ignored.
- Reset values: MISO 0, LED_CMD 2'b00, FRAME_DONE 0, FRAME_ERR 0, BUSY 0, FSM IDLE, all counters and shift registers 0.
- Reset mid-frame: the FSM returns to IDLE and no pulse is emitted. If CS is still low when reset releases, the current frame is ignored; only a fresh synced CS fall starts a new frame.

## Timing
- Edge-detect latency is SYNC_STAGES+1 CLK cycles from the pin transition to the state change.
- MISO for byte 0 bit 7 is valid SYNC_STAGES+1 cycles after CS falls.
- Each subsequent MISO bit changes SYNC_STAGES+1 cycles after the SCLK fall.
- Master constraints:
  - SCLK high and low phases each ≥ 2·(SYNC_STAGES+1) CLK cycles
  - CS fall to first SCLK rise ≥ 2·(SYNC_STAGES+1) cycles
  - last SCLK fall to CS rise ≥ SYNC_STAGES+1 cycles
- FRAME_DONE, FRAME_ERR and the LED_CMD update are registered; each is visible the cycle after the triggering synced edge.
- Snapshot inputs are sampled once per frame and may change freely mid-frame.

## Structure
- Package jstk_pkg holds:
  - JSTK_FRAME_BYTES = 5
  - JSTK_LED_CMD_BIT = 7
  - byte-index localparams for X_LO, X_HI, Y_LO, Y_HI and BTN
  - FSM state enum {IDLE, ACTIVE}
- Sub-module sync_edge: SYNC_STAGES FF synchronizer plus rise/fall pulse outputs, instantiated for CS, SCLK and MOSI. MOSI uses only the level output.

## Test plan
- X=0x2A5, Y=0x13C, BUTTONS=3'b101; master sends 0x81,0,0,0,0 at SCLK = CLK/16 → MISO bytes A5,02,3C,01,05; LED_CMD=01; one FRAME_DONE pulse; BUSY high only during CS low.
- Byte 0 = 0x03 (bit 7 clear) → LED_CMD holds its previous value; the frame still ends with FRAME_DONE.
- CS raised after 3 bytes, then after 5 bytes + 4 bits → FRAME_ERR pulse each time, no FRAME_DONE.
- 7-byte frame → bytes 5 and 6 read 0x00; FRAME_ERR at CS rise.
- X_POS changed mid-frame from 0x2A5 to 0x000 → the current frame still returns A5,02; the next frame returns 00,00.
- RST asserted during byte 2 with CS held low → outputs return to reset values; SCLK activity until CS rises is ignored; the next full frame completes normally with FRAME_DONE.
